// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline sequencer: FSM states, PC source
// select codes and pipeline register indices.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_REDIRECT = 2'd3
    } pipe_state_t;

    localparam logic [1:0] PCSEL_SEQ    = 2'b00;
    localparam logic [1:0] PCSEL_JUMP   = 2'b01;
    localparam logic [1:0] PCSEL_BRANCH = 2'b10;
    localparam logic [1:0] PCSEL_TRAP   = 2'b11;

    localparam int IFID  = 0;
    localparam int IDEX  = 1;
    localparam int EXMEM = 2;
    localparam int MEMWB = 3;

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 5-stage core. Merges hazard stall/flush,
// branch redirect, instruction/data memory wait and interrupt entry into
// PC enable/select and per-register hold/bubble controls (Mealy outputs).
// Optional interrupt support is compiled in with `define PIPE_CTRL_IRQ_EN,
// which adds the DRAIN/REDIRECT states and the drain counter.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int DRAIN_CYCLES = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       HAZ_STALL,
    input  logic       HAZ_FLUSH,
    input  logic       BR_TAKEN,
    input  logic       IMEM_READY,
    input  logic       DMEM_REQ,
    input  logic       DMEM_ACK,
    input  logic       IRQ,
    output logic       PC_EN,
    output logic [1:0] PC_SEL,
    output logic [3:0] STAGE_EN,
    output logic [3:0] BUBBLE,
    output logic       EPC_CAPTURE,
    output logic       TRAP_TAKEN
);

    pipe_state_t state;
    pipe_state_t state_next;
    logic        dmem_freeze;
    logic        mem_stall;

`ifdef PIPE_CTRL_IRQ_EN
    logic [1:0] drain_cnt;
    logic [1:0] drain_cnt_next;
`else
    // Without interrupt support these inputs have no effect.
    logic       irq_unused;
    localparam int DRAIN_CYCLES_UNUSED = DRAIN_CYCLES;
    assign irq_unused = IRQ;
`endif

    assign dmem_freeze = DMEM_REQ && !DMEM_ACK;
    // In MEM_WAIT the request is already known outstanding, so only the ack matters.
    assign mem_stall   = (state == ST_MEM_WAIT) ? !DMEM_ACK : dmem_freeze;

    // Next-state and Mealy output decode; reset forces a fully bubbled pipe.
    always_comb begin
        state_next  = state;
        PC_EN       = 1'b0;
        PC_SEL      = PCSEL_SEQ;
        STAGE_EN    = 4'b0000;
        BUBBLE      = 4'b0000;
        EPC_CAPTURE = 1'b0;
        TRAP_TAKEN  = 1'b0;
`ifdef PIPE_CTRL_IRQ_EN
        drain_cnt_next = drain_cnt;
`endif
        case (state)
            ST_RUN, ST_MEM_WAIT: begin
                state_next = ST_RUN;
                if (mem_stall) begin
                    BUBBLE[MEMWB] = 1'b1;
                    state_next    = ST_MEM_WAIT;
                end else if (BR_TAKEN) begin
                    PC_SEL      = PCSEL_BRANCH;
                    PC_EN       = 1'b1;
                    BUBBLE      = 4'b0011;
                    STAGE_EN    = 4'b1100;
                end else if (HAZ_STALL) begin
                    BUBBLE[IDEX] = 1'b1;
                    STAGE_EN     = 4'b1100;
                end else if (HAZ_FLUSH) begin
                    PC_SEL       = PCSEL_JUMP;
                    PC_EN        = 1'b1;
                    BUBBLE[IFID] = 1'b1;
                    STAGE_EN     = 4'b1110;
`ifdef PIPE_CTRL_IRQ_EN
                end else if (IRQ) begin
                    EPC_CAPTURE    = 1'b1;
                    BUBBLE[IFID]   = 1'b1;
                    STAGE_EN       = 4'b1110;
                    drain_cnt_next = DRAIN_CYCLES[1:0];
                    state_next     = ST_DRAIN;
`endif
                end else begin
                    STAGE_EN     = 4'b1111;
                    PC_EN        = IMEM_READY;
                    BUBBLE[IFID] = !IMEM_READY;
                end
            end
`ifdef PIPE_CTRL_IRQ_EN
            ST_DRAIN: begin
                if (dmem_freeze) begin
                    BUBBLE[MEMWB] = 1'b1;
                end else begin
                    BUBBLE[IFID]   = 1'b1;
                    STAGE_EN       = 4'b1110;
                    drain_cnt_next = drain_cnt - 2'd1;
                    if (drain_cnt <= 2'd1) begin
                        state_next = ST_REDIRECT;
                    end
                end
            end
            ST_REDIRECT: begin
                PC_SEL       = PCSEL_TRAP;
                PC_EN        = 1'b1;
                TRAP_TAKEN   = 1'b1;
                BUBBLE[IFID] = 1'b1;
                STAGE_EN     = 4'b1110;
                state_next   = ST_RUN;
            end
`endif
            default: begin
                state_next = ST_RUN;
            end
        endcase
        if (RST) begin
            PC_EN       = 1'b0;
            PC_SEL      = PCSEL_SEQ;
            STAGE_EN    = 4'b0000;
            BUBBLE      = 4'b1111;
            EPC_CAPTURE = 1'b0;
            TRAP_TAKEN  = 1'b0;
        end
    end

    // State register with synchronous reset back to RUN.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

`ifdef PIPE_CTRL_IRQ_EN
    // Drain counter; a pending drain is discarded by reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            drain_cnt <= 2'd0;
        end else begin
            drain_cnt <= drain_cnt_next;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios with literal
// expectations followed by randomized traffic checked against a
// behavioural model. Honours `define PIPE_CTRL_IRQ_EN like the design.
module tb_pipe_ctrl;

    localparam int DRAIN = 2;
`ifdef PIPE_CTRL_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, haz_stall, haz_flush, br_taken, imem_ready;
    logic       dmem_req, dmem_ack, irq;
    logic       pc_en, epc_capture, trap_taken;
    logic [1:0] pc_sel;
    logic [3:0] stage_en, bubble;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    // Model state: waiting on data memory, drain cycles left, redirect pending.
    bit m_wait   = 1'b0;
    int m_drain  = 0;
    bit m_redir  = 1'b0;

    pipe_ctrl #(.DRAIN_CYCLES(DRAIN)) dut (
        .CLK(clk), .RST(rst), .HAZ_STALL(haz_stall), .HAZ_FLUSH(haz_flush),
        .BR_TAKEN(br_taken), .IMEM_READY(imem_ready), .DMEM_REQ(dmem_req),
        .DMEM_ACK(dmem_ack), .IRQ(irq), .PC_EN(pc_en), .PC_SEL(pc_sel),
        .STAGE_EN(stage_en), .BUBBLE(bubble), .EPC_CAPTURE(epc_capture),
        .TRAP_TAKEN(trap_taken)
    );

    // Free-running core clock.
    always #5 clk = ~clk;

    // Model: expected {PC_EN, PC_SEL, STAGE_EN, BUBBLE, EPC, TRAP} for the
    // current inputs, and advance the model across the coming edge.
    task automatic modelStep(output logic [12:0] exp);
        logic       e_pc, e_epc, e_trap;
        logic [1:0] e_sel;
        logic [3:0] e_st, e_bb;
        bit         stall;
        e_pc = 0; e_sel = 2'b00; e_st = 4'b0000; e_bb = 4'b0000; e_epc = 0; e_trap = 0;
        if (rst) begin
            e_bb = 4'b1111;
            m_wait = 0; m_drain = 0; m_redir = 0;
        end else if (m_redir) begin
            e_pc = 1; e_sel = 2'b11; e_trap = 1; e_bb = 4'b0001; e_st = 4'b1110;
            m_redir = 0;
        end else if (m_drain > 0) begin
            if (dmem_req && !dmem_ack) begin
                e_bb = 4'b1000;
            end else begin
                e_bb = 4'b0001; e_st = 4'b1110;
                m_drain = m_drain - 1;
                if (m_drain == 0) m_redir = 1;
            end
        end else begin
            stall = m_wait ? !dmem_ack : (dmem_req && !dmem_ack);
            m_wait = stall;
            if (stall) begin
                e_bb = 4'b1000;
            end else if (br_taken) begin
                e_pc = 1; e_sel = 2'b10; e_bb = 4'b0011; e_st = 4'b1100;
            end else if (haz_stall) begin
                e_bb = 4'b0010; e_st = 4'b1100;
            end else if (haz_flush) begin
                e_pc = 1; e_sel = 2'b01; e_bb = 4'b0001; e_st = 4'b1110;
            end else if (IRQ_ON && irq) begin
                e_epc = 1; e_bb = 4'b0001; e_st = 4'b1110;
                m_drain = DRAIN;
            end else begin
                e_st = 4'b1111;
                e_pc = imem_ready;
                e_bb = imem_ready ? 4'b0000 : 4'b0001;
            end
        end
        exp = {e_pc, e_sel, e_st, e_bb, e_epc, e_trap};
    endtask

    // Compare all DUT outputs against the model's expectation.
    task automatic checkOutput(input logic [12:0] exp);
        logic [12:0] act;
        act = {pc_en, pc_sel, stage_en, bubble, epc_capture, trap_taken};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL model_cmp cycle=%0d got pc_en/sel/stage/bubble/epc/trap=%b required=%b",
                     cycle, act, exp);
        end
    endtask

    // Hand-computed literal expectation on one output.
    task automatic checkLit(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle=%0d got=%b required=%b", name, cycle, act, exp);
        end
    endtask

    // Drive one cycle of inputs after the edge, check at the falling edge.
    task automatic applyStimulus(input logic r, input logic hs, input logic hf, input logic br,
                                 input logic im, input logic rq, input logic ak, input logic iq);
        logic [12:0] exp;
        @(posedge clk);
        #1;
        rst = r; haz_stall = hs; haz_flush = hf; br_taken = br;
        imem_ready = im; dmem_req = rq; dmem_ack = ak; irq = iq;
        @(negedge clk);
        cycle++;
        modelStep(exp);
        checkOutput(exp);
    endtask

    // Shorthand for an idle, ready cycle.
    task automatic idle();
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    endtask

    initial begin
        rst = 1; haz_stall = 0; haz_flush = 0; br_taken = 0;
        imem_ready = 1; dmem_req = 0; dmem_ack = 0; irq = 0;

        // Reset
        applyStimulus(1, 0, 0, 0, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 1, 0, 0, 0);
        checkLit("rst_pc_en", {3'b0, pc_en}, 4'b0000);
        checkLit("rst_stage_en", stage_en, 4'b0000);
        checkLit("rst_bubble", bubble, 4'b1111);
        idle();
        checkLit("run_stage_en", stage_en, 4'b1111);
        checkLit("run_pc", {1'b0, pc_en, pc_sel}, 4'b0100);

        // Data memory wait of three cycles then ack
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 1, 0, 0);
            checkLit("memwait_pc_en", {3'b0, pc_en}, 4'b0000);
            checkLit("memwait_stage_en", stage_en, 4'b0000);
            checkLit("memwait_bubble", bubble, 4'b1000);
        end
        applyStimulus(0, 0, 0, 0, 1, 1, 1, 0);
        checkLit("ack_stage_en", stage_en, 4'b1111);
        idle();
        checkLit("after_ack_stage_en", stage_en, 4'b1111);

        // Branch beats load-use stall
        applyStimulus(0, 1, 0, 1, 1, 0, 0, 0);
        checkLit("br_stall_sel", {1'b0, pc_en, pc_sel}, 4'b0110);
        checkLit("br_stall_bubble", bubble, 4'b0011);

        // Jump redirect still loads PC without fetch data
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
        checkLit("flush_sel", {1'b0, pc_en, pc_sel}, 4'b0101);
        checkLit("flush_bubble", bubble, 4'b0001);

        // Fetch not ready on a plain cycle
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkLit("imem_pc_en", {3'b0, pc_en}, 4'b0000);
        checkLit("imem_bubble", bubble, 4'b0001);
        idle();

`ifdef PIPE_CTRL_IRQ_EN
        // Interrupt entry: accept, two drains, redirect once
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 1);
        checkLit("irq_epc", {3'b0, epc_capture}, 4'b0001);
        checkLit("irq_pc_en", {3'b0, pc_en}, 4'b0000);
        for (int i = 0; i < DRAIN; i++) begin
            idle();
            checkLit("drain_pc_en_trap", {2'b0, pc_en, trap_taken}, 4'b0000);
        end
        idle();
        checkLit("redirect", {trap_taken, pc_en, pc_sel}, 4'b1111);
        idle();
        checkLit("post_redirect", {trap_taken, pc_en, pc_sel}, 4'b0100);

        // Interrupt with a two-cycle data stall inside the drain
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 1);
        idle();
        applyStimulus(0, 0, 0, 0, 1, 1, 0, 0);
        checkLit("drain_freeze_bubble", bubble, 4'b1000);
        applyStimulus(0, 0, 0, 0, 1, 1, 0, 0);
        checkLit("drain_freeze_trap", {3'b0, trap_taken}, 4'b0000);
        idle();
        checkLit("drain_last_trap", {3'b0, trap_taken}, 4'b0000);
        idle();
        checkLit("delayed_redirect", {trap_taken, pc_en, pc_sel}, 4'b1111);

        // Reset during drain discards the trap
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 1);
        idle();
        applyStimulus(1, 0, 0, 0, 1, 0, 0, 0);
        checkLit("rst_in_drain_bubble", bubble, 4'b1111);
        idle();
        checkLit("rst_drain_run", {trap_taken, 1'b0, pc_en, 1'b0}, 4'b0010);
        idle();
        checkLit("rst_drain_no_trap", {3'b0, trap_taken}, 4'b0000);
`else
        // Interrupt is ignored when not compiled in
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 1);
        checkLit("irq_off_epc", {3'b0, epc_capture}, 4'b0000);
        checkLit("irq_off_stage_en", stage_en, 4'b1111);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 1);
        checkLit("irq_off_pc", {trap_taken, pc_en, pc_sel}, 4'b0100);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(63) == 0),
                          ($urandom_range(4) == 0),
                          ($urandom_range(5) == 0),
                          ($urandom_range(6) == 0),
                          ($urandom_range(5) != 0),
                          ($urandom_range(2) == 0),
                          ($urandom_range(1) == 0),
                          ($urandom_range(11) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
